hub75_rx: RTL and testbench

//  HUB75 panel-side receiver/decoder: samples the HUB75 bus (clock, strobe, row select, RGB1/2) produced by
//  the panel driver, rebuilds each shifted row bit-plane and emits it as a pixel/plane stream with

---
 rtl/hub75_pkg.sv | 26 ++
 rtl/hub75_rx_linebuf.sv | 69 ++++++
 rtl/hub75_rx.sv | 243 ++++++++++++++++++++++++
 tb/tb_hub75_rx.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 bus receiver.
// Bit bundle layout matches the order the six colour pins are sampled in.
package hub75_pkg;

    localparam int seg_count_p = 2;

    typedef struct packed {
        logic r2;
        logic g2;
        logic b2;
        logic r1;
        logic g1;
        logic b1;
    } hub75_bits_t;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_DRAIN = 1'b1
    } rx_state_e;

    // Pick the {R,G,B} triple of one display segment.
    function automatic logic [2:0] seg_rgb(hub75_bits_t b, logic seg);
        return seg ? {b.r2, b.g2, b.b2} : {b.r1, b.g1, b.b1};
    endfunction

endpackage

// File: rtl/hub75_rx_linebuf.sv
// Ping-pong row store: one bank fills from the bus while the other drains.
// Banks are committed and freed strictly in order, so two pointers suffice.
module hub75_rx_linebuf
    import hub75_pkg::*;
#(
    parameter int hpixel_p = 64,
    localparam int col_w_p = $clog2(hpixel_p)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [col_w_p-1:0] wr_col,
    input  hub75_bits_t        wr_data,
    input  logic               swap,
    input  logic               free,
    input  logic [col_w_p-1:0] rd_col,
    output hub75_bits_t        rd_data,
    output logic               fill_sel,
    output logic               drain_sel,
    output logic               fill_busy,
    output logic               pend_busy
);

    hub75_bits_t mem [2][hpixel_p];
    logic [1:0]  busy_q;
    logic        fill_q;
    logic        drain_q;
    logic        wr_bank;
    logic        wr_ok;

    // A bit arriving with the commit belongs to the bank that becomes the fill bank.
    assign wr_bank   = swap ? ~fill_q : fill_q;
    assign wr_ok     = wr_en & ~busy_q[wr_bank];
    assign rd_data   = mem[drain_q][rd_col];
    assign fill_sel  = fill_q;
    assign drain_sel = drain_q;
    assign fill_busy = busy_q[fill_q];
    assign pend_busy = busy_q[~drain_q];

    // Storage write; a busy bank is never overwritten.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_bank][wr_col] <= wr_data;
    end

    // Bank pointers and per-bank busy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            fill_q  <= 1'b0;
            drain_q <= 1'b0;
        end else if (flush) begin
            busy_q  <= '0;
            fill_q  <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            if (swap) begin
                busy_q[fill_q] <= 1'b1;
                fill_q         <= ~fill_q;
            end
            if (free) begin
                busy_q[drain_q] <= 1'b0;
                drain_q         <= ~drain_q;
            end
        end
    end

endmodule

// File: rtl/hub75_rx.sv
// HUB75 bus receiver: rebuilds shifted rows and replays them as a beat stream.
// Bus pins are asynchronous to clk and pass through two-flop synchronisers.
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int hpixel_p   = 64,
    parameter int vpixel_p   = 64,
    parameter int bpp_p      = 8,
    parameter int segments_p = seg_count_p,
    localparam int rows_p       = vpixel_p / segments_p,
    localparam int addr_width_p = $clog2(hpixel_p * vpixel_p),
    localparam int plane_w_p    = $clog2(bpp_p)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    input  logic                    I_CLK,
    input  logic                    I_STB,
    input  logic                    I_A,
    input  logic                    I_B,
    input  logic                    I_C,
    input  logic                    I_D,
    input  logic                    I_E,
    input  logic                    I_R1,
    input  logic                    I_G1,
    input  logic                    I_B1,
    input  logic                    I_R2,
    input  logic                    I_G2,
    input  logic                    I_B2,
    output logic                    o_px_valid,
    input  logic                    i_px_ready,
    output logic [addr_width_p-1:0] o_px_addr,
    output logic [plane_w_p-1:0]    o_px_plane,
    output logic [2:0]              o_px_rgb,
    output logic                    o_frame_done,
    output logic                    o_overflow,
    output logic                    o_len_err
);

    localparam int col_w_p = $clog2(hpixel_p);
    localparam int cnt_w_p = $clog2(hpixel_p + 1);
    localparam int row_w_p = $clog2(rows_p);

    localparam logic [0:0] ST_IDLE  = RX_IDLE;
    localparam logic [0:0] ST_DRAIN = RX_DRAIN;

    logic [12:0] pin_w;
    logic [12:0] meta_q;
    logic [12:0] sync_q;
    logic        clk_d_q;
    logic        stb_d_q;
    logic        clk_rise;
    logic        stb_rise;
    logic        en;

    hub75_bits_t         px_w;
    logic [row_w_p-1:0]  row_w;

    logic [cnt_w_p-1:0]   col_q;
    logic                 ovr_q;
    logic [plane_w_p-1:0] plane_q;
    logic [row_w_p-1:0]   last_row_q;
    logic                 have_q;
    logic                 len_err_q;
    logic                 ovf_q;
    logic [row_w_p-1:0]   bank_row_q [2];
    logic [plane_w_p-1:0] bank_plane_q [2];
    logic [plane_w_p-1:0] next_plane;
    logic                 len_ok;
    logic                 commit;
    logic                 wr_en;
    logic [col_w_p-1:0]   wr_col;

    logic [0:0]           state_q;
    logic [col_w_p-1:0]   rd_col_q;
    logic                 seg_q;
    logic                 last_col;
    logic                 beat_acc;
    logic                 last_beat;

    hub75_bits_t          rd_data;
    logic                 fill_sel;
    logic                 drain_sel;
    logic                 fill_busy;
    logic                 pend_busy;

    logic [row_w_p-1:0]      cur_row;
    logic [plane_w_p-1:0]    cur_plane;
    logic [addr_width_p-1:0] seg_a;
    logic [addr_width_p-1:0] row_a;
    logic [addr_width_p-1:0] col_a;
    logic [addr_width_p-1:0] addr_w;

    assign pin_w = {I_CLK, I_STB, I_E, I_D, I_C, I_B, I_A,
                    I_R2, I_G2, I_B2, I_R1, I_G1, I_B1};

    assign en       = i_enable;
    assign px_w     = sync_q[5:0];
    assign row_w    = sync_q[6 +: row_w_p];
    assign clk_rise = sync_q[12] & ~clk_d_q;
    assign stb_rise = sync_q[11] & ~stb_d_q;

    // Two-flop synchronisers plus the edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= '0;
            sync_q  <= '0;
            clk_d_q <= 1'b0;
            stb_d_q <= 1'b0;
        end else begin
            meta_q  <= pin_w;
            sync_q  <= meta_q;
            clk_d_q <= sync_q[12];
            stb_d_q <= sync_q[11];
        end
    end

    // The first commit after reset or enable always starts at plane 0.
    always_comb begin
        next_plane = '0;
        if (have_q && row_w == last_row_q)
            next_plane = (plane_q == plane_w_p'(bpp_p - 1)) ? '0 : plane_q + 1'b1;
    end

    assign len_ok = (col_q == cnt_w_p'(hpixel_p)) & ~ovr_q;
    assign commit = en & stb_rise & len_ok & ~fill_busy;
    assign wr_en  = en & clk_rise & (stb_rise | (col_q < cnt_w_p'(hpixel_p)));
    assign wr_col = stb_rise ? '0 : col_q[col_w_p-1:0];

    // Column counting, row/plane tracking and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            ovr_q        <= 1'b0;
            plane_q      <= '0;
            last_row_q   <= '0;
            have_q       <= 1'b0;
            len_err_q    <= 1'b0;
            ovf_q        <= 1'b0;
            bank_row_q   <= '{default: '0};
            bank_plane_q <= '{default: '0};
        end else if (!en) begin
            col_q      <= '0;
            ovr_q      <= 1'b0;
            plane_q    <= '0;
            last_row_q <= '0;
            have_q     <= 1'b0;
            len_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (stb_rise) begin
            col_q <= cnt_w_p'(clk_rise);
            ovr_q <= 1'b0;
            if (!len_ok) begin
                len_err_q <= 1'b1;
            end else if (fill_busy) begin
                ovf_q <= 1'b1;
            end else begin
                plane_q                <= next_plane;
                last_row_q             <= row_w;
                have_q                 <= 1'b1;
                bank_row_q[fill_sel]   <= row_w;
                bank_plane_q[fill_sel] <= next_plane;
            end
        end else if (clk_rise) begin
            if (col_q == cnt_w_p'(hpixel_p))
                ovr_q <= 1'b1;
            else
                col_q <= col_q + 1'b1;
        end
    end

    assign last_col  = rd_col_q == col_w_p'(hpixel_p - 1);
    assign beat_acc  = en & (state_q == ST_DRAIN) & i_px_ready;
    assign last_beat = beat_acc & seg_q & last_col;

    // Drain FSM: segment 0 then 1 per column; chains straight into a queued bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_col_q <= '0;
            seg_q    <= 1'b0;
        end else if (!en) begin
            state_q  <= ST_IDLE;
            rd_col_q <= '0;
            seg_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (commit)
                        state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (beat_acc) begin
                        seg_q <= ~seg_q;
                        if (seg_q)
                            rd_col_q <= last_col ? '0 : rd_col_q + 1'b1;
                        if (last_beat && !pend_busy && !commit)
                            state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    hub75_rx_linebuf #(
        .hpixel_p (hpixel_p)
    ) u_linebuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (~en),
        .wr_en     (wr_en),
        .wr_col    (wr_col),
        .wr_data   (px_w),
        .swap      (commit),
        .free      (last_beat),
        .rd_col    (rd_col_q),
        .rd_data   (rd_data),
        .fill_sel  (fill_sel),
        .drain_sel (drain_sel),
        .fill_busy (fill_busy),
        .pend_busy (pend_busy)
    );

    assign cur_row   = bank_row_q[drain_sel];
    assign cur_plane = bank_plane_q[drain_sel];
    assign seg_a     = addr_width_p'(seg_q);
    assign row_a     = addr_width_p'(cur_row);
    assign col_a     = addr_width_p'(rd_col_q);
    assign addr_w    = (seg_a * addr_width_p'(rows_p) + row_a)
                       * addr_width_p'(hpixel_p) + col_a;

    assign o_px_valid   = state_q == ST_DRAIN;
    assign o_px_addr    = o_px_valid ? addr_w : '0;
    assign o_px_plane   = o_px_valid ? cur_plane : '0;
    assign o_px_rgb     = o_px_valid ? seg_rgb(rd_data, seg_q) : 3'b000;
    assign o_frame_done = last_beat
                          & (cur_plane == plane_w_p'(bpp_p - 1))
                          & (cur_row == row_w_p'(rows_p - 1));
    assign o_overflow   = ovf_q;
    assign o_len_err    = len_err_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: bus-level row shifting, beat scoreboard,
// plane table, back-pressure, overflow, length error and reset cases.
module tb_hub75_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_enable = 1'b0;
    logic        I_CLK = 1'b0, I_STB = 1'b0;
    logic        I_A = 1'b0, I_B = 1'b0, I_C = 1'b0, I_D = 1'b0, I_E = 1'b0;
    logic        I_R1 = 1'b0, I_G1 = 1'b0, I_B1 = 1'b0;
    logic        I_R2 = 1'b0, I_G2 = 1'b0, I_B2 = 1'b0;
    logic        i_px_ready = 1'b0;
    logic        o_px_valid;
    logic [11:0] o_px_addr;
    logic [2:0]  o_px_plane;
    logic [2:0]  o_px_rgb;
    logic        o_frame_done;
    logic        o_overflow;
    logic        o_len_err;

    hub75_rx #(
        .hpixel_p   (64),
        .vpixel_p   (64),
        .bpp_p      (8),
        .segments_p (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (i_enable),
        .I_CLK        (I_CLK),
        .I_STB        (I_STB),
        .I_A          (I_A),
        .I_B          (I_B),
        .I_C          (I_C),
        .I_D          (I_D),
        .I_E          (I_E),
        .I_R1         (I_R1),
        .I_G1         (I_G1),
        .I_B1         (I_B1),
        .I_R2         (I_R2),
        .I_G2         (I_G2),
        .I_B2         (I_B2),
        .o_px_valid   (o_px_valid),
        .i_px_ready   (i_px_ready),
        .o_px_addr    (o_px_addr),
        .o_px_plane   (o_px_plane),
        .o_px_rgb     (o_px_rgb),
        .o_frame_done (o_frame_done),
        .o_overflow   (o_overflow),
        .o_len_err    (o_len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [2:0]  plane;
        logic [2:0]  rgb;
        logic        fd;
    } beat_t;

    typedef struct {
        int row;
        int exp_plane;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    beat_t obs[$];
    beat_t exp_q[$];
    int    rd_i = 0;
    int    fd_n = 0;
    int    fd_addr = 0;
    int    fd_plane = 0;
    int    m_row = 0;
    int    m_plane = 0;
    bit    m_have = 0;

    // Every accepted beat is logged; the stimulus process scores the log.
    always @(negedge clk) begin
        if (rst_n && i_enable && o_px_valid && i_px_ready) begin
            obs.push_back({o_px_addr, o_px_plane, o_px_rgb, o_frame_done});
            if (o_frame_done) begin
                fd_n++;
                fd_addr  = int'(o_px_addr);
                fd_plane = int'(o_px_plane);
            end
        end
    end

    initial begin
        #990000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [5:0] pix(input int c, input int seed);
        logic [5:0] v;
        if (seed == 0)
            v = (c % 2 == 1) ? 6'b001_010 : 6'b010_100;
        else
            v = 6'((c * 5 + seed * 11) ^ (c >> 2) ^ seed);
        return v;
    endfunction

    task automatic expect_row(input int row, input int seed, input int plane);
        beat_t      e;
        logic [5:0] b;
        for (int c = 0; c < 64; c++) begin
            b = pix(c, seed);
            for (int s = 0; s < 2; s++) begin
                e.addr  = 12'((s * 32 + row) * 64 + c);
                e.plane = 3'(plane);
                e.rgb   = (s == 1) ? b[5:3] : b[2:0];
                e.fd    = (s == 1 && c == 63 && plane == 7 && row == 31);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic shift_bit(input logic [5:0] b);
        I_CLK = 1'b0;
        {I_R2, I_G2, I_B2, I_R1, I_G1, I_B1} = b;
        tick(2);
        I_CLK = 1'b1;
        tick(2);
    endtask

    task automatic strobe(input int row);
        logic [4:0] r;
        r = 5'(row);
        I_CLK = 1'b0;
        {I_E, I_D, I_C, I_B, I_A} = r;
        tick(2);
        I_STB = 1'b1;
        tick(2);
        I_STB = 1'b0;
        tick(2);
    endtask

    task automatic send_row(input int row, input int seed, input int ncols, input bit commits);
        int pl;
        for (int c = 0; c < ncols; c++)
            shift_bit(pix(c, seed));
        if (commits) begin
            pl = (m_have && row == m_row) ? ((m_plane == 7) ? 0 : m_plane + 1) : 0;
            m_have  = 1;
            m_row   = row;
            m_plane = pl;
            expect_row(row, seed, pl);
        end
        strobe(row);
    endtask

    task automatic wait_obs(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (obs.size() < target && k < budget) begin
            tick(1);
            k++;
        end
        check({name, " beats arrived"}, obs.size() >= target, 1);
    endtask

    task automatic score(input string name);
        int    bad;
        beat_t e;
        bad = 0;
        while (rd_i < obs.size()) begin
            if (exp_q.size() == 0) begin
                bad++;
            end else begin
                e = exp_q.pop_front();
                if (e != obs[rd_i])
                    bad++;
            end
            rd_i++;
        end
        bad += exp_q.size();
        exp_q.delete();
        check({name, " beat stream"}, bad, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        m_have  = 0;
        m_row   = 0;
        m_plane = 0;
        exp_q.delete();
        rd_i = obs.size();
    endtask

    initial begin
        vec_t  tv[14];
        int    base;
        int    fd0;
        int    n0;
        int    diff;
        logic [18:0] snap;

        for (int i = 0; i < 12; i++)
            tv[i] = '{5, i % 8};
        tv[12] = '{6, 0};
        tv[13] = '{6, 1};

        // Reset state
        tick(3);
        check("rst valid", o_px_valid, 0);
        check("rst addr", o_px_addr, 0);
        check("rst plane", o_px_plane, 0);
        check("rst rgb", o_px_rgb, 0);
        check("rst frame_done", o_frame_done, 0);
        check("rst overflow", o_overflow, 0);
        check("rst len_err", o_len_err, 0);
        rst_n = 1'b1;
        i_enable = 1'b1;
        tick(2);

        // 1: single row 5, free-running ready
        base = obs.size();
        i_px_ready = 1'b1;
        send_row(5, 0, 64, 1);
        wait_obs("t1", base + 128, 400);
        check("t1 b0 addr", obs[base].addr, 320);
        check("t1 b0 rgb", obs[base].rgb, 3'b100);
        check("t1 b0 plane", obs[base].plane, 0);
        check("t1 b1 addr", obs[base+1].addr, 2368);
        check("t1 b1 rgb", obs[base+1].rgb, 3'b010);
        check("t1 b127 addr", obs[base+127].addr, 2431);
        check("t1 b127 rgb", obs[base+127].rgb, 3'b001);
        score("t1");

        // 2: plane sequencing table
        do_reset();
        for (int i = 0; i < 14; i++) begin
            base = obs.size();
            send_row(tv[i].row, i + 1, 64, 1);
            wait_obs("t2", base + 128, 400);
            check($sformatf("t2 vec%0d plane", i), obs[base].plane, tv[i].exp_plane);
        end
        score("t2");

        // 3: full frame, one frame_done on the very last beat
        do_reset();
        base = obs.size();
        fd0  = fd_n;
        for (int r = 0; r < 32; r++)
            for (int p = 0; p < 8; p++)
                send_row(r, r * 8 + p + 1, 64, 1);
        wait_obs("t3", base + 256 * 128, 2000);
        score("t3");
        check("t3 frame_done count", fd_n - fd0, 1);
        check("t3 frame_done addr", fd_addr, 4095);
        check("t3 frame_done plane", fd_plane, 7);
        check("t3 overflow", o_overflow, 0);

        // 4: back-pressure mid-drain
        base = obs.size();
        send_row(7, 3, 64, 1);
        wait_obs("t4 pre", base + 20, 200);
        i_px_ready = 1'b0;
        tick(1);
        n0   = obs.size();
        snap = {o_px_valid, o_px_addr, o_px_plane, o_px_rgb};
        diff = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if ({o_px_valid, o_px_addr, o_px_plane, o_px_rgb} !== snap)
                diff++;
        end
        check("t4 valid held", snap[18], 1);
        check("t4 outputs held", diff, 0);
        check("t4 no beats stalled", obs.size(), n0);
        i_px_ready = 1'b1;
        wait_obs("t4", base + 128, 400);
        score("t4");

        // 5: both banks busy, third row overflows
        base = obs.size();
        i_px_ready = 1'b0;
        send_row(1, 4, 64, 1);
        send_row(2, 5, 64, 1);
        tick(2);
        check("t5 no overflow yet", o_overflow, 0);
        send_row(3, 6, 64, 0);
        tick(2);
        check("t5 overflow", o_overflow, 1);
        check("t5 no beats", obs.size(), base);
        i_px_ready = 1'b1;
        wait_obs("t5", base + 256, 600);
        score("t5");

        // 6: short row, enable flush, reset mid-drain
        base = obs.size();
        send_row(2, 7, 63, 0);
        tick(4);
        check("t6 len_err", o_len_err, 1);
        tick(20);
        check("t6 no beats", obs.size(), base);
        check("t6 idle", o_px_valid, 0);
        i_enable = 1'b0;
        tick(1);
        i_enable = 1'b1;
        tick(1);
        check("t6 len_err cleared", o_len_err, 0);
        check("t6 overflow cleared", o_overflow, 0);
        m_have = 0;
        i_px_ready = 1'b0;
        send_row(9, 8, 64, 1);
        tick(2);
        check("t6 draining", o_px_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6 rst valid", o_px_valid, 0);
        check("t6 rst addr", o_px_addr, 0);
        check("t6 rst plane", o_px_plane, 0);
        check("t6 rst rgb", o_px_rgb, 0);
        check("t6 rst frame_done", o_frame_done, 0);
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check("t6 idle after reset", o_px_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
